nv_nvdla_sdp_wdma_dat_pack: RTL
===============================

# nv_nvdla_sdp_wdma_dat_pack

Parametrised SDP write-DMA data packer. It buffers per-atom output data from the SDP datapath and consumes write commands (base address plus atom count). It emits combined address/mask/data DMA write requests of up to `REQ_ATOMS` atoms, each aligned so that no request crosses a `REQ_ATOMS`-atom address boundary. It sits between the SDP core datapath and the DMA write arbiter, and reports layer completion and interrupts to the register block.

## Interface
- `ATOM_W`, default 256: bits per atom. `ATOM_BYTES` = `ATOM_W`/8.
- `REQ_ATOMS`, default 2: maximum atoms per DMA request. Legal values are 1, 2 and 4.
- `FIFO_DEPTH`, default 16: data FIFO entries. Must be a power of two and ≥ `REQ_ATOMS`.
- `ADDR_W`, default 64: DMA address width.
- `SIZE_W`, default 13: command size width.

Ports:
- `nvdla_core_clk` in, 1: the single clock.
- `nvdla_core_rstn` in, 1: reset, asynchronous and active-low.
- `op_load` in, 1: layer start pulse.
- `reg2dp_interrupt_ptr` in, 1: interrupt pointer, latched at `op_load`.
- `cmd_pvld` in, 1 / `cmd_prdy` out, 1: command handshake.
- `cmd_addr` in, `ADDR_W`: command start address. Low log2(`ATOM_BYTES`) bits are ignored and treated as 0.
- `cmd_size` in, `SIZE_W`: number of atoms minus 1.
- `cmd_last` in, 1: marks the final command of the layer.
- `dat_pvld` in, 1 / `dat_prdy` out, 1 / `dat_pd` in, `ATOM_W`: one atom per beat.
- `dma_wr_req_vld` out, 1 / `dma_wr_req_rdy` in, 1: DMA request handshake.
- `dma_wr_req_addr` out, `ADDR_W`: request address.
- `dma_wr_req_mask` out, `REQ_ATOMS`: bit k = lane k holds a valid atom.
- `dma_wr_req_data` out, `REQ_ATOMS`*`ATOM_W`: lane k = `[k*ATOM_W +: ATOM_W]`.
- `dp2reg_done` out, 1: layer-complete pulse.
- `intr_req_pvld` out, 1 / `intr_req_ptr` out, 1: interrupt request.
- `dp2reg_status_unequal` out, 1: sticky mismatch flag.

## Operation
**Data FIFO**
- Depth `FIFO_DEPTH`, with a count of `log2(FIFO_DEPTH)+1` bits.
- `dat_prdy` = count < `FIFO_DEPTH`.
- A write and a pop in the same cycle are both honoured, with count adjusted by +1 − popped.
- Pointers wrap modulo `FIFO_DEPTH`.
- Up to `REQ_ATOMS` head entries are readable at once.

**Command state machine**
- States are IDLE and BUSY.
- IDLE: `cmd_prdy`=1. On `cmd_pvld`, latch addr (atom-aligned), remaining = `cmd_size`+1 and last, then go to BUSY.
- BUSY: `cmd_prdy`=0.
- Each issue step computes:
  - `bnd` = `REQ_ATOMS` − ((addr/`ATOM_BYTES`) mod `REQ_ATOMS`)
  - n = min(`bnd`, remaining)
- Issue when FIFO count ≥ n and the output register is empty or being accepted this cycle. Issuing does four things:
  - Pops n entries.
  - Loads the output register with addr, mask = (1<<n)−1, and atoms in lanes 0..n−1. Unused lanes are driven 0.
  - Sets addr += n*`ATOM_BYTES`.
  - Sets remaining −= n.
- When remaining reaches 0, return to IDLE and flag the issued request as terminal-of-layer if last=1.

**Completion**
- When a terminal-of-layer request is accepted (vld&rdy), the block pulses `dp2reg_done` and `intr_req_pvld` for one cycle, on the following cycle.
- `intr_req_ptr` carries the pointer latched at the most recent `op_load`.
- At the same acceptance, `dp2reg_status_unequal` is set if the FIFO is non-empty or `dat_pvld`=1.

**op_load**
- Clears `dp2reg_status_unequal`.
- Latches `reg2dp_interrupt_ptr`.
- Does not disturb an in-flight command or the FIFO.
- If it occurs in the same cycle as a set condition, the set wins.

## Timing
Reset values:
- All outputs are 0, except `cmd_prdy`=1 and `dat_prdy`=1.
- The FIFO is empty and the state is IDLE.
- The latched pointer and the sticky flag are 0.

Latency and handshakes:
- An atom written at cycle t can be issued at the t+1 edge, so the earliest `dma_wr_req_vld` is at cycle t+2.
- A command accepted at cycle t can issue at the t+1 edge.
- There is a minimum one-cycle `cmd_prdy` bubble between commands.
- The output is a single register. `dma_wr_req_*` stay stable while vld=1 and rdy=0.
- Full throughput is one request per cycle when rdy=1 and data is available.

Boundary conditions:
- FIFO full: `dat_prdy`=0, and a pop in the same cycle does not re-open `dat_prdy` until the next cycle.
- `cmd_size`=0: a single one-atom request.
- Address arithmetic wraps modulo 2^`ADDR_W`.
- Asynchronous reset mid-operation drops the in-flight command, the FIFO contents and any pending request.

## Test plan
1. Aligned command (`REQ_ATOMS`=2): `cmd_addr`=0x1000, size=3, 4 atoms A0–A3 → requests (0x1000, mask 2'b11, {A1,A0}) then (0x1040, 2'b11, {A3,A2}). With data prefilled and rdy=1, the requests appear on consecutive cycles.
2. Unaligned start: addr=0x1020, size=2 → (0x1020, 2'b01, lane0=A0, lane1=0), then (0x1040, 2'b11, {A2,A1}). Also verify `REQ_ATOMS`=4 with addr=0x1060, size=5 → masks 4'b0001, 4'b1111, 4'b0001.
3. Backpressure: hold rdy=0 for 10 cycles with valid asserted → outputs are stable; 16 atoms fill the FIFO; `dat_prdy`=0 on the 17th beat; no data is lost after release.
4. Completion: `op_load` with `reg2dp_interrupt_ptr`=1, then a last command of 1 atom → exactly one `dp2reg_done` pulse and `intr_req_pvld` pulse with `intr_req_ptr`=1, one cycle after acceptance; `unequal`=0.
5. Mismatch: last command of 2 atoms while 3 atoms are supplied → `dp2reg_status_unequal`=1 after the final acceptance, and it is cleared by the next `op_load`.
6. Reset mid-command: assert `nvdla_core_rstn`=0 after the first of two requests → `dma_wr_req_vld`=0 immediately, `cmd_prdy`=1, and FIFO empty after release.

Source files
------------

// File: rtl/nv_nvdla_sdp_wdma_dat_pack.sv
`default_nettype none
// ============================================================================
// Module   : nv_nvdla_sdp_wdma_dat_pack
// Brief    : SDP write-DMA data packer. Buffers datapath atoms in a FIFO and
//            packs them, per write command, into boundary-aligned DMA write
//            requests of up to REQ_ATOMS atoms. Reports layer completion.
// Revision : 1.0 - initial release
// ============================================================================
module nv_nvdla_sdp_wdma_dat_pack #(
  parameter int ATOM_W     = 256,
  parameter int REQ_ATOMS  = 2,
  parameter int FIFO_DEPTH = 16,   // power of two, >= 2 and >= REQ_ATOMS
  parameter int ADDR_W     = 64,
  parameter int SIZE_W     = 13
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rstn,
  input  logic                        op_load,
  input  logic                        reg2dp_interrupt_ptr,
  input  logic                        cmd_pvld,
  output logic                        cmd_prdy,
  input  logic [ADDR_W-1:0]           cmd_addr,
  input  logic [SIZE_W-1:0]           cmd_size,
  input  logic                        cmd_last,
  input  logic                        dat_pvld,
  output logic                        dat_prdy,
  input  logic [ATOM_W-1:0]           dat_pd,
  output logic                        dma_wr_req_vld,
  input  logic                        dma_wr_req_rdy,
  output logic [ADDR_W-1:0]           dma_wr_req_addr,
  output logic [REQ_ATOMS-1:0]        dma_wr_req_mask,
  output logic [REQ_ATOMS*ATOM_W-1:0] dma_wr_req_data,
  output logic                        dp2reg_done,
  output logic                        intr_req_pvld,
  output logic                        intr_req_ptr,
  output logic                        dp2reg_status_unequal
);

  localparam int C_ATOM_BYTES = ATOM_W / 8;
  localparam int C_LOG2_AB    = $clog2(C_ATOM_BYTES);
  localparam int C_LOG2_RA    = (REQ_ATOMS > 1) ? $clog2(REQ_ATOMS) : 1;
  localparam int C_PTR_W      = $clog2(FIFO_DEPTH);
  localparam int C_CNT_W      = C_PTR_W + 1;
  localparam int C_REM_W      = SIZE_W + 1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t                      r_state, w_state_nxt;
  logic [ATOM_W-1:0]           r_mem [FIFO_DEPTH];
  logic [C_PTR_W-1:0]          r_wr_ptr, r_rd_ptr;
  logic [C_CNT_W-1:0]          r_count;
  logic [ADDR_W-1:0]           r_addr;
  logic [C_REM_W-1:0]          r_rem;
  logic                        r_last;
  logic                        r_vld, r_term;
  logic [ADDR_W-1:0]           r_req_addr;
  logic [REQ_ATOMS-1:0]        r_req_mask;
  logic [REQ_ATOMS*ATOM_W-1:0] r_req_data;
  logic                        r_done, r_intr, r_ptr, r_unequal;

  logic                        w_push, w_issue, w_final, w_can_load, w_term_acc;
  logic [C_CNT_W-1:0]          w_off, w_bnd, w_n, w_pop_n;
  logic [REQ_ATOMS-1:0]        w_mask;
  logic [REQ_ATOMS*ATOM_W-1:0] w_data;

  // Atom offset of the current address inside its REQ_ATOMS-atom window.
  generate
    if (REQ_ATOMS == 1) begin : g_off_single
      assign w_off = '0;
    end else begin : g_off_multi
      assign w_off = C_CNT_W'(r_addr[C_LOG2_AB +: C_LOG2_RA]);
    end
  endgenerate

  assign w_bnd      = C_CNT_W'(REQ_ATOMS) - w_off;
  assign w_n        = (C_REM_W'(w_bnd) > r_rem) ? C_CNT_W'(r_rem) : w_bnd;
  assign w_can_load = !r_vld || dma_wr_req_rdy;
  assign w_issue    = (r_state == ST_BUSY) && (r_count >= w_n) && w_can_load;
  assign w_final    = w_issue && (r_rem == C_REM_W'(w_n));
  assign w_pop_n    = w_issue ? w_n : '0;
  assign w_push     = dat_pvld && dat_prdy;
  assign dat_prdy   = (r_count < C_CNT_W'(FIFO_DEPTH));
  assign w_term_acc = r_vld && dma_wr_req_rdy && r_term;

  // Head-of-FIFO lanes: lane k carries entry rd_ptr+k when k < n, else zero.
  generate
    for (genvar k = 0; k < REQ_ATOMS; k++) begin : g_lane
      logic [C_PTR_W-1:0] w_idx;
      assign w_idx     = r_rd_ptr + C_PTR_W'(k);
      assign w_mask[k] = (C_CNT_W'(k) < w_n);
      assign w_data[k*ATOM_W +: ATOM_W] = w_mask[k] ? r_mem[w_idx] : '0;
    end
  endgenerate

  // FIFO storage; contents need no reset because the count gates every read.
  always_ff @(posedge nvdla_core_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= dat_pd;
  end

  // FIFO pointers and occupancy; push and multi-entry pop may coincide.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= r_rd_ptr + C_PTR_W'(w_pop_n);
      r_count  <= r_count + C_CNT_W'(w_push) - w_pop_n;
    end
  end

  // Command state register.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) r_state <= ST_IDLE;
    else                  r_state <= w_state_nxt;
  end

  // Next state and command ready: accept in IDLE, leave BUSY on the last issue.
  always_comb begin
    w_state_nxt = r_state;
    cmd_prdy    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_prdy = 1'b1;
        if (cmd_pvld) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (w_final) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Command context: aligned address and remaining atoms, advanced per issue.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_addr <= '0;
      r_rem  <= '0;
      r_last <= 1'b0;
    end else if (cmd_pvld && cmd_prdy) begin
      r_addr <= cmd_addr & ~ADDR_W'(C_ATOM_BYTES - 1);
      r_rem  <= C_REM_W'(cmd_size) + 1'b1;
      r_last <= cmd_last;
    end else if (w_issue) begin
      r_addr <= r_addr + (ADDR_W'(w_n) << C_LOG2_AB);
      r_rem  <= r_rem - C_REM_W'(w_n);
    end
  end

  // Single output register; holds steady until accepted.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_vld      <= 1'b0;
      r_term     <= 1'b0;
      r_req_addr <= '0;
      r_req_mask <= '0;
      r_req_data <= '0;
    end else if (w_issue) begin
      r_vld      <= 1'b1;
      r_term     <= w_final && r_last;
      r_req_addr <= r_addr;
      r_req_mask <= w_mask;
      r_req_data <= w_data;
    end else if (dma_wr_req_rdy) begin
      r_vld  <= 1'b0;
      r_term <= 1'b0;
    end
  end

  // Completion pulses, interrupt pointer and sticky leftover-data flag.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_done    <= 1'b0;
      r_intr    <= 1'b0;
      r_ptr     <= 1'b0;
      r_unequal <= 1'b0;
    end else begin
      r_done <= w_term_acc;
      r_intr <= w_term_acc;
      if (op_load) r_ptr <= reg2dp_interrupt_ptr;
      if (w_term_acc && ((r_count != '0) || dat_pvld)) r_unequal <= 1'b1;
      else if (op_load)                                r_unequal <= 1'b0;
    end
  end

  assign dma_wr_req_vld        = r_vld;
  assign dma_wr_req_addr       = r_req_addr;
  assign dma_wr_req_mask       = r_req_mask;
  assign dma_wr_req_data       = r_req_data;
  assign dp2reg_done           = r_done;
  assign intr_req_pvld         = r_intr;
  assign intr_req_ptr          = r_ptr;
  assign dp2reg_status_unequal = r_unequal;

endmodule
`default_nettype wire
